control_unit_mc: RTL and testbench

Multi-cycle, parametrised control unit for the 19-bit CPU. It replaces the single-cycle opcode decoder and sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK. It waits on a memory ready handshake, tracks call-stack depth for CALL/RET, and raises a sticky fault on illegal opcodes or stack over/underflow. It sits between the instruction register/flags and the datapath control bus.

---
 rtl/control_unit_mc_pkg.sv | 73 +++++++
 rtl/call_depth_counter.sv | 32 +++
 rtl/control_unit_mc.sv | 164 ++++++++++++++++
 tb/tb_control_unit_mc.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_mc_pkg.sv
// Shared opcode map, FSM state encoding and ALU select encoding for the multi-cycle control unit.
// Latency: n/a (types, constants and pure decode functions only).
// Backpressure: n/a.
package control_unit_mc_pkg;

   // Opcode width of the instruction register; control_unit_mc OPCODE_W must match.
   localparam int OP_W = 5;

   localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
   localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
   localparam logic [OP_W-1:0] OP_MUL  = 5'd2;
   localparam logic [OP_W-1:0] OP_DIV  = 5'd3;
   localparam logic [OP_W-1:0] OP_AND  = 5'd4;
   localparam logic [OP_W-1:0] OP_OR   = 5'd5;
   localparam logic [OP_W-1:0] OP_XOR  = 5'd6;
   localparam logic [OP_W-1:0] OP_NOT  = 5'd7;
   localparam logic [OP_W-1:0] OP_JMP  = 5'd8;
   localparam logic [OP_W-1:0] OP_BEQ  = 5'd9;
   localparam logic [OP_W-1:0] OP_BNE  = 5'd10;
   localparam logic [OP_W-1:0] OP_LD   = 5'd11;
   localparam logic [OP_W-1:0] OP_ST   = 5'd12;
   localparam logic [OP_W-1:0] OP_CALL = 5'd13;
   localparam logic [OP_W-1:0] OP_RET  = 5'd14;

   // Debug-visible state encoding; the values appear on the STATE port.
   typedef enum logic [2:0] {
      CU_IDLE      = 3'd0,
      CU_FETCH     = 3'd1,
      CU_DECODE    = 3'd2,
      CU_EXECUTE   = 3'd3,
      CU_MEM       = 3'd4,
      CU_WRITEBACK = 3'd5,
      CU_FAULT     = 3'd6
   } cu_state_t;

   // ALU select; NOP is what the bus idles at.
   typedef enum logic [3:0] {
      ALU_NOP = 4'd0,
      ALU_ADD = 4'd1,
      ALU_SUB = 4'd2,
      ALU_MUL = 4'd3,
      ALU_DIV = 4'd4,
      ALU_AND = 4'd5,
      ALU_OR  = 4'd6,
      ALU_XOR = 4'd7,
      ALU_NOT = 4'd8
   } alu_op_t;

   // Opcodes are dense from ADD up to RET; everything above is reserved.
   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      return op <= OP_RET;
   endfunction

   // Register-to-register ALU instructions occupy the bottom of the map.
   function automatic logic is_alu_op(input logic [OP_W-1:0] op);
      return op <= OP_NOT;
   endfunction

   function automatic alu_op_t alu_decode(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD:  return ALU_ADD;
         OP_SUB:  return ALU_SUB;
         OP_MUL:  return ALU_MUL;
         OP_DIV:  return ALU_DIV;
         OP_AND:  return ALU_AND;
         OP_OR:   return ALU_OR;
         OP_XOR:  return ALU_XOR;
         OP_NOT:  return ALU_NOT;
         default: return ALU_NOP;
      endcase
   endfunction

endpackage

// File: rtl/call_depth_counter.sv
// Saturating up/down counter tracking CALL nesting depth, with full/empty flags.
// Latency: depth updates on the clock edge after an inc/dec strobe; flags are combinational from depth.
// Backpressure: none; inc at full and dec at empty are ignored (the FSM never issues them).
module call_depth_counter #(
   parameter int STACK_DEPTH = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               inc,
   input  logic                               dec,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
   output logic                               full,
   output logic                               empty
);

   localparam int             W     = $clog2(STACK_DEPTH + 1);
   localparam logic [W-1:0]   D_MAX = W'(STACK_DEPTH);

   // Depth register: count pushes up and pops down, never wrapping past either end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         depth <= '0;
      else if (inc && !dec && depth != D_MAX)
         depth <= depth + W'(1);
      else if (dec && !inc && depth != '0)
         depth <= depth - W'(1);
   end

   assign full  = (depth == D_MAX);
   assign empty = (depth == '0);

endmodule

// File: rtl/control_unit_mc.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives the datapath strobes.
// Latency: 3 cycles (jump/branch), 4 (ALU, ST, CALL, RET), 5 (LD) with zero-wait memory.
// Backpressure: FETCH and MEM stall while mem_ready is low; en=0 freezes everything and gates all strobes.
module control_unit_mc
   import control_unit_mc_pkg::*;
#(
   parameter int OPCODE_W    = 5,
   parameter int FLAG_W      = 4,
   parameter int STACK_DEPTH = 8,
   parameter int ALU_OP_W    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [FLAG_W-1:0]   flags,
   input  logic                mem_ready,
   output logic                pc_inc,
   output logic                pc_load,
   output logic                ir_load,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                reg_we,
   output logic                mem_re,
   output logic                mem_we,
   output logic                sp_push,
   output logic                sp_pop,
   output logic                fault,
   output logic [2:0]          state
);

   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

   cu_state_t           state_q;
   cu_state_t           state_d;
   logic [OPCODE_W-1:0] op_q;
   logic [OP_W-1:0]     op_k;
   logic                op_legal;
   logic [DEPTH_W-1:0]  depth;
   logic                stack_full;
   logic                stack_empty;
   logic                unused_ok;

   // Decode always works in the package opcode width.
   assign op_k     = OP_W'(op_q);
   assign op_legal = is_legal_op(OP_W'(opcode));

   // Only the zero flag steers branches; depth is consumed via full/empty.
   assign unused_ok = ^{flags[FLAG_W-1:1], depth};

   call_depth_counter #(
      .STACK_DEPTH (STACK_DEPTH)
   ) u_depth (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (sp_push),
      .dec   (sp_pop),
      .depth (depth),
      .full  (stack_full),
      .empty (stack_empty)
   );

   // State register; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= CU_IDLE;
      else
         state_q <= state_d;
   end

   // Op register: captures the instruction register once, in DECODE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         op_q <= '0;
      else if (en && state_q == CU_DECODE)
         op_q <= opcode;
   end

   // Next-state: en=0 holds; stack limits are checked before any MEM access is issued.
   always_comb begin
      state_d = state_q;
      if (en) begin
         case (state_q)
            CU_IDLE:      state_d = CU_FETCH;
            CU_FETCH:     if (mem_ready) state_d = CU_DECODE;
            CU_DECODE:    state_d = op_legal ? CU_EXECUTE : CU_FAULT;
            CU_EXECUTE: begin
               if (is_alu_op(op_k))
                  state_d = CU_WRITEBACK;
               else begin
                  case (op_k)
                     OP_LD, OP_ST: state_d = CU_MEM;
                     OP_CALL:      state_d = stack_full  ? CU_FAULT : CU_MEM;
                     OP_RET:       state_d = stack_empty ? CU_FAULT : CU_MEM;
                     default:      state_d = CU_FETCH;
                  endcase
               end
            end
            CU_MEM:       if (mem_ready) state_d = (op_k == OP_LD) ? CU_WRITEBACK : CU_FETCH;
            CU_WRITEBACK: state_d = CU_FETCH;
            CU_FAULT:     state_d = CU_FAULT;
            default:      state_d = CU_FAULT;
         endcase
      end
   end

   // Strobes: combinational from state, op and inputs; all forced low when en=0.
   always_comb begin
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      ir_load = 1'b0;
      alu_op  = '0;
      reg_we  = 1'b0;
      mem_re  = 1'b0;
      mem_we  = 1'b0;
      sp_push = 1'b0;
      sp_pop  = 1'b0;
      if (en) begin
         case (state_q)
            CU_FETCH: begin
               mem_re = 1'b1;
               if (mem_ready) begin
                  ir_load = 1'b1;
                  pc_inc  = 1'b1;
               end
            end
            CU_EXECUTE: begin
               if (is_alu_op(op_k))
                  alu_op = ALU_OP_W'(alu_decode(op_k));
               else begin
                  case (op_k)
                     OP_JMP:  pc_load = 1'b1;
                     OP_BEQ:  pc_load = flags[0];
                     OP_BNE:  pc_load = !flags[0];
                     default: pc_load = 1'b0;
                  endcase
               end
            end
            CU_MEM: begin
               // LD/RET read, ST/CALL write: exactly one request line per cycle.
               if (op_k == OP_LD || op_k == OP_RET)
                  mem_re = 1'b1;
               else
                  mem_we = 1'b1;
               if (mem_ready) begin
                  if (op_k == OP_CALL) begin
                     sp_push = 1'b1;
                     pc_load = 1'b1;
                  end
                  if (op_k == OP_RET) begin
                     sp_pop  = 1'b1;
                     pc_load = 1'b1;
                  end
               end
            end
            CU_WRITEBACK: reg_we = 1'b1;
            default: ;
         endcase
      end
   end

   assign fault = (state_q == CU_FAULT);
   assign state = state_q;

endmodule

// File: tb/tb_control_unit_mc.sv
// Scoreboard bench for control_unit_mc: per-cycle stimulus and expected outputs are queued per instruction.
// Latency: each queued entry is one clock; outputs are compared on the falling edge.
// Backpressure: mem_ready wait cycles and en=0 holds are part of the queued stimulus.
module tb_control_unit_mc;
   import control_unit_mc_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [4:0] opcode;
   logic [3:0] flags;
   logic       mem_ready;
   logic       pc_inc, pc_load, ir_load, reg_we, mem_re, mem_we, sp_push, sp_pop, fault;
   logic [3:0] alu_op;
   logic [2:0] state;

   always #5 clk = ~clk;

   control_unit_mc #(
      .OPCODE_W    (5),
      .FLAG_W      (4),
      .STACK_DEPTH (8),
      .ALU_OP_W    (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .opcode    (opcode),
      .flags     (flags),
      .mem_ready (mem_ready),
      .pc_inc    (pc_inc),
      .pc_load   (pc_load),
      .ir_load   (ir_load),
      .alu_op    (alu_op),
      .reg_we    (reg_we),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .sp_push   (sp_push),
      .sp_pop    (sp_pop),
      .fault     (fault),
      .state     (state)
   );

   typedef struct packed {
      logic [2:0] st;
      logic       pc_inc;
      logic       pc_load;
      logic       ir_load;
      logic [3:0] alu;
      logic       reg_we;
      logic       mem_re;
      logic       mem_we;
      logic       sp_push;
      logic       sp_pop;
      logic       fault;
   } obs_t;

   typedef struct {
      logic       en;
      logic [4:0] opc;
      logic [3:0] flg;
      logic       rdy;
      obs_t       exp;
      int         tag;
   } cyc_t;

   // Opcode driven outside DECODE: proves the unit works from its latched copy.
   localparam logic [4:0] JUNK = 5'h1F;
   localparam int         MAX_DEPTH = 8;

   cyc_t sb[$];
   int   n_chk   = 0;
   int   n_pass  = 0;
   int   depth_m = 0;
   int   tag_id  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic obs_t mk(input logic [2:0] st);
      obs_t o;
      o       = '0;
      o.st    = st;
      o.fault = (st == CU_FAULT);
      return o;
   endfunction

   function automatic obs_t obs_now();
      return {state, pc_inc, pc_load, ir_load, alu_op, reg_we, mem_re, mem_we, sp_push, sp_pop, fault};
   endfunction

   function automatic logic [3:0] exp_alu(input logic [4:0] op);
      case (op)
         OP_ADD:  return ALU_ADD;
         OP_SUB:  return ALU_SUB;
         OP_MUL:  return ALU_MUL;
         OP_DIV:  return ALU_DIV;
         OP_AND:  return ALU_AND;
         OP_OR:   return ALU_OR;
         OP_XOR:  return ALU_XOR;
         OP_NOT:  return ALU_NOT;
         default: return ALU_NOP;
      endcase
   endfunction

   task automatic push(input logic e, input logic [4:0] opc, input logic [3:0] flg, input logic rdy, input obs_t x);
      cyc_t c;
      c.en  = e;
      c.opc = opc;
      c.flg = flg;
      c.rdy = rdy;
      c.exp = x;
      c.tag = tag_id;
      sb.push_back(c);
   endtask

   task automatic push_fault(input logic [3:0] flg);
      for (int i = 0; i < 4; i++)
         push((i % 2) == 0, JUNK, flg, 1'b1, mk(CU_FAULT));
   endtask

   // Queue one instruction: fwait/mwait low-ready cycles in FETCH/MEM, hold en=0 cycles on MEM entry,
   // abort stops with the MEM request still pending.
   task automatic instr(input logic [4:0] op, input logic [3:0] flg, input int fwait, input int mwait,
                        input int hold, input bit abort);
      obs_t x;
      tag_id++;
      x = mk(CU_FETCH);
      x.mem_re = 1'b1;
      for (int i = 0; i < fwait; i++) push(1'b1, JUNK, ~flg, 1'b0, x);
      x.ir_load = 1'b1;
      x.pc_inc  = 1'b1;
      push(1'b1, JUNK, ~flg, 1'b1, x);
      push(1'b1, op, ~flg, 1'b1, mk(CU_DECODE));
      if (op > OP_RET) begin
         push_fault(flg);
         return;
      end
      x = mk(CU_EXECUTE);
      if (op <= OP_NOT) begin
         x.alu = exp_alu(op);
         push(1'b1, JUNK, flg, 1'b1, x);
         x = mk(CU_WRITEBACK);
         x.reg_we = 1'b1;
         push(1'b1, JUNK, ~flg, 1'b1, x);
         return;
      end
      if (op == OP_JMP) x.pc_load = 1'b1;
      if (op == OP_BEQ) x.pc_load = flg[0];
      if (op == OP_BNE) x.pc_load = ~flg[0];
      push(1'b1, JUNK, flg, 1'b1, x);
      if (op == OP_JMP || op == OP_BEQ || op == OP_BNE) return;
      if ((op == OP_CALL && depth_m == MAX_DEPTH) || (op == OP_RET && depth_m == 0)) begin
         push_fault(flg);
         return;
      end
      for (int i = 0; i < hold; i++) push(1'b0, JUNK, ~flg, 1'b1, mk(CU_MEM));
      x = mk(CU_MEM);
      if (op == OP_LD || op == OP_RET) x.mem_re = 1'b1;
      else                             x.mem_we = 1'b1;
      for (int i = 0; i < mwait; i++) push(1'b1, JUNK, ~flg, 1'b0, x);
      if (abort) return;
      if (op == OP_CALL) begin
         x.sp_push = 1'b1;
         x.pc_load = 1'b1;
         depth_m++;
      end
      if (op == OP_RET) begin
         x.sp_pop  = 1'b1;
         x.pc_load = 1'b1;
         depth_m--;
      end
      push(1'b1, JUNK, ~flg, 1'b1, x);
      if (op == OP_LD) begin
         x = mk(CU_WRITEBACK);
         x.reg_we = 1'b1;
         push(1'b1, JUNK, ~flg, 1'b1, x);
      end
   endtask

   // Drain the scoreboard: drive just after the rising edge, compare on the falling edge.
   task automatic run();
      cyc_t c;
      while (sb.size() > 0) begin
         c         = sb.pop_front();
         en        = c.en;
         opcode    = c.opc;
         flags     = c.flg;
         mem_ready = c.rdy;
         @(negedge clk);
         check($sformatf("i%0d_st%0d", c.tag, c.exp.st), obs_now(), c.exp);
         @(posedge clk);
         #1;
      end
   endtask

   // Assert reset mid-cycle, check it is immediate and holds, release with en=1 and expect one IDLE cycle.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_async", obs_now(), mk(CU_IDLE));
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_hold", obs_now(), mk(CU_IDLE));
      end
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      depth_m = 0;
      tag_id++;
      push(1'b1, JUNK, 4'h0, 1'b1, mk(CU_IDLE));
   endtask

   initial begin
      rst_n     = 1'b1;
      en        = 1'b0;
      opcode    = 5'h0;
      flags     = 4'h0;
      mem_ready = 1'b0;
      #2;
      do_reset();

      // All eight ALU ops, alternating a FETCH wait cycle.
      for (int k = 0; k < 8; k++) instr(5'(k), 4'(k), k % 2, 0, 0, 1'b0);
      instr(OP_BEQ, 4'b0001, 0, 0, 0, 1'b0);
      instr(OP_BEQ, 4'b0000, 0, 0, 0, 1'b0);
      instr(OP_BNE, 4'b0000, 0, 0, 0, 1'b0);
      instr(OP_BNE, 4'b1111, 0, 0, 0, 1'b0);
      instr(OP_JMP, 4'b0000, 2, 0, 0, 1'b0);
      instr(OP_LD,  4'b0000, 0, 3, 0, 1'b0);
      instr(OP_ST,  4'b0000, 1, 2, 0, 1'b0);
      run();

      // Fill the call stack; the ninth CALL must fault in EXECUTE.
      for (int k = 0; k < 9; k++) instr(OP_CALL, 4'h0, 0, k % 3, 0, 1'b0);
      run();

      do_reset();
      instr(OP_RET, 4'h0, 0, 0, 0, 1'b0);
      run();

      do_reset();
      instr(5'b11111, 4'h0, 0, 0, 0, 1'b0);
      run();

      // en=0 holds in MEM ignore mem_ready; depth must move by exactly one CALL.
      do_reset();
      instr(OP_LD,   4'h0, 0, 1, 3, 1'b0);
      instr(OP_CALL, 4'h0, 0, 0, 2, 1'b0);
      instr(OP_RET,  4'h0, 0, 0, 2, 1'b0);
      instr(OP_RET,  4'h0, 0, 0, 0, 1'b0);
      run();

      // Reset while a LD read request is pending.
      do_reset();
      instr(OP_LD, 4'h0, 0, 2, 0, 1'b1);
      run();
      en        = 1'b1;
      mem_ready = 1'b0;
      #1;
      check("pending_mem_re", {31'd0, mem_re}, 32'd1);
      do_reset();
      run();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
